// File: rtl/regfile_wb.sv
// 32x32 register file with a single write-back stage register in front of the array.
// The stage register supports stall, flush and read bypass, and commits count in a wrapping counter.
module regfile_wb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic        wb_stall,
  input  logic        wb_flush,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic [4:0]  dbg_a,
  output logic [31:0] dbg_d,
  output logic        wb_valid,
  output logic [4:0]  wb_addr,
  output logic [15:0] commit_cnt
);

  logic [31:0] regs [32];
  logic        stage_valid;
  logic [4:0]  stage_addr;
  logic [31:0] stage_data;
  logic        commit;

  // A pending write retires whenever the stage is not stalled; a flush alone does not stop it.
  assign commit = stage_valid && !wb_stall;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= 1'b0;
      stage_addr  <= '0;
      stage_data  <= '0;
    end else if (wb_flush) begin
      stage_valid <= 1'b0;
    end else if (!wb_stall) begin
      stage_valid <= we && (wa != 5'd0);
      stage_addr  <= wa;
      stage_data  <= wd;
    end
  end

  // NOTE: the array must read zero straight out of reset, so it is a flop array with async clear, not a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[stage_addr] <= stage_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      commit_cnt <= '0;
    else if (commit) commit_cnt <= commit_cnt + 16'd1;
  end

  always_comb begin
    rd1 = regs[ra1];
    rd2 = regs[ra2];
    if (stage_valid && stage_addr == ra1) rd1 = stage_data;
    if (stage_valid && stage_addr == ra2) rd2 = stage_data;
    if (ra1 == 5'd0) rd1 = '0;
    if (ra2 == 5'd0) rd2 = '0;
  end

  assign dbg_d    = (dbg_a == 5'd0) ? 32'd0 : regs[dbg_a];
  assign wb_valid = stage_valid;
  assign wb_addr  = stage_addr;

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: stimulus pushes expected commits to a queue,
// a negedge monitor pops them as the DUT retires writes; reads are checked inline.
module tb_regfile_wb;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } commit_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        wb_stall;
  logic        wb_flush;
  logic [4:0]  ra1, ra2, dbg_a;
  logic [31:0] rd1, rd2, dbg_d;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [15:0] commit_cnt;

  int tests = 0;
  int fails = 0;
  commit_t exp_q[$];

  regfile_wb dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .wb_stall(wb_stall), .wb_flush(wb_flush),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .dbg_a(dbg_a), .dbg_d(dbg_d),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .commit_cnt(commit_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic stall, input logic flush);
    we = w; wa = a; wd = d; wb_stall = stall; wb_flush = flush;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    commit_t c;
    c.addr = a;
    c.data = d;
    exp_q.push_back(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a commit happens at the coming edge whenever the stage is valid and not stalled.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wb_valid === 1'b1 && wb_stall === 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_commit", 32'(wb_addr), 32'hFFFF_FFFF);
      end else begin
        commit_t c;
        c = exp_q.pop_front();
        check("commit_addr", 32'(wb_addr), 32'(c.addr));
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    ra1 = 5'd5; ra2 = 5'd7; dbg_a = 5'd5;
    #3;
    check("reset_rd1", rd1, 32'd0);
    check("reset_rd2", rd2, 32'd0);
    check("reset_dbg", dbg_d, 32'd0);
    check("reset_valid", 32'(wb_valid), 32'd0);
    check("reset_addr", 32'(wb_addr), 32'd0);
    check("reset_cnt", 32'(commit_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Basic write with bypass then commit
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0); push(5'd5, 32'hDEADBEEF);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    ra1 = 5'd5; dbg_a = 5'd5;
    #1;
    check("basic_bypass_rd1", rd1, 32'hDEADBEEF);
    check("basic_dbg_before", dbg_d, 32'd0);
    check("basic_valid", 32'(wb_valid), 32'd1);
    check("basic_addr", 32'(wb_addr), 32'd5);
    step();
    check("basic_dbg_after", dbg_d, 32'hDEADBEEF);
    check("basic_cnt", 32'(commit_cnt), 32'd1);
    check("basic_rd1_array", rd1, 32'hDEADBEEF);
    check("basic_valid_clr", 32'(wb_valid), 32'd0);

    // Register 0 write is ignored
    drive(1'b1, 5'd0, 32'h1234, 1'b0, 1'b0);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    ra1 = 5'd0;
    #1;
    check("r0_valid", 32'(wb_valid), 32'd0);
    check("r0_rd1", rd1, 32'd0);
    step();
    check("r0_cnt", 32'(commit_cnt), 32'd1);

    // Stall holds the stage; bypass works, array unchanged
    drive(1'b1, 5'd7, 32'hA5, 1'b0, 1'b0); push(5'd7, 32'hA5);
    step();
    drive(1'b1, 5'd3, 32'hFFFF, 1'b1, 1'b0);
    ra2 = 5'd7; dbg_a = 5'd7;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", 32'(wb_valid), 32'd1);
      check("stall_addr", 32'(wb_addr), 32'd7);
      check("stall_rd2", rd2, 32'hA5);
      check("stall_dbg", dbg_d, 32'd0);
      check("stall_cnt", 32'(commit_cnt), 32'd1);
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    step();
    check("stall_commit_dbg", dbg_d, 32'hA5);
    check("stall_commit_cnt", 32'(commit_cnt), 32'd2);
    check("stall_valid_clr", 32'(wb_valid), 32'd0);

    // Flush with stall discards
    drive(1'b1, 5'd9, 32'h55, 1'b0, 1'b0);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    ra1 = 5'd9; dbg_a = 5'd9;
    #1;
    check("flush_stall_valid", 32'(wb_valid), 32'd0);
    check("flush_stall_dbg", dbg_d, 32'd0);
    check("flush_stall_rd1", rd1, 32'd0);
    check("flush_stall_cnt", 32'(commit_cnt), 32'd2);

    // Flush without stall still commits and does not load new input
    drive(1'b1, 5'd9, 32'h55, 1'b0, 1'b0); push(5'd9, 32'h55);
    step();
    drive(1'b1, 5'd4, 32'h44, 1'b0, 1'b1);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    #1;
    check("flush_valid", 32'(wb_valid), 32'd0);
    check("flush_dbg", dbg_d, 32'h55);
    check("flush_cnt", 32'(commit_cnt), 32'd3);

    // Write r1..r31 back to back
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'h1000_0000 + 32'(i), 1'b0, 1'b0);
      push(5'(i), 32'h1000_0000 + 32'(i));
      step();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    step();
    ra1 = 5'd17; ra2 = 5'd31; dbg_a = 5'd1;
    #1;
    check("fill_rd1", rd1, 32'h1000_0011);
    check("fill_rd2", rd2, 32'h1000_001F);
    check("fill_dbg", dbg_d, 32'h1000_0001);
    check("fill_cnt", 32'(commit_cnt), 32'd34);

    // Pending write then async reset between edges
    drive(1'b1, 5'd12, 32'hCAFE, 1'b0, 1'b0);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    ra1 = 5'd12; ra2 = 5'd31; dbg_a = 5'd5;
    rst_n = 1'b0;
    #1;
    check("arst_rd1", rd1, 32'd0);
    check("arst_rd2", rd2, 32'd0);
    check("arst_dbg", dbg_d, 32'd0);
    check("arst_valid", 32'(wb_valid), 32'd0);
    check("arst_addr", 32'(wb_addr), 32'd0);
    check("arst_cnt", 32'(commit_cnt), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      dbg_a = 5'(i);
      #1;
      check("arst_array", dbg_d, 32'd0);
    end

    // Counter wrap
    step();
    for (int i = 0; i < 65535; i++) begin
      drive(1'b1, 5'd1, 32'(i), 1'b0, 1'b0);
      push(5'd1, 32'(i));
      step();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    step();
    check("wrap_pre_cnt", 32'(commit_cnt), 32'hFFFF);
    drive(1'b1, 5'd2, 32'hBEEF, 1'b0, 1'b0); push(5'd2, 32'hBEEF);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    step();
    dbg_a = 5'd2;
    #1;
    check("wrap_cnt", 32'(commit_cnt), 32'd0);
    check("wrap_dbg", dbg_d, 32'hBEEF);

    step();
    step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_wb.md
REGFILE_WB -- requirements
Module: regfile_wb

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port we, input, 1 bit: write request from the write-back stage.
REQ-004 SHALL have port wa, input, 5 bits: destination register number from the upstream 4:1 write-address mux.
REQ-005 SHALL have port wd, input, 32 bits: write data.
REQ-006 SHALL have port wb_stall, input, 1 bit: hold the stage register and suppress commit.
REQ-007 SHALL have port wb_flush, input, 1 bit: invalidate the stage register.
REQ-008 SHALL have ports ra1 and ra2, input, 5 bits each: read addresses.
REQ-009 SHALL have ports rd1 and rd2, output, 32 bits each: read data.
REQ-010 SHALL have port dbg_a, input, 5 bits, and port dbg_d, output, 32 bits: debug read port, no bypass.
REQ-011 SHALL have ports wb_valid (output, 1 bit) and wb_addr (output, 5 bits): stage register state, for hazard logic.
REQ-012 SHALL have port commit_cnt, output, 16 bits: count of committed writes.

Function
REQ-013 SHALL contain a 32x32 register array plus one stage register {valid, addr[4:0], data[31:0]}.
REQ-014 The stage register SHALL load at the clock edge when wb_stall=0 and wb_flush=0: valid<=(we && wa!=0), addr<=wa, data<=wd.
REQ-015 When wb_stall=1 and wb_flush=0, the stage register SHALL hold its contents.
REQ-016 When wb_flush=1, the stage register SHALL clear valid at the edge, regardless of wb_stall; flush has priority.
REQ-017 A commit SHALL occur at an edge where stage valid=1 and wb_stall=0: array[addr]<=data, and commit_cnt increments by 1.
REQ-018 A flush without stall SHALL still commit the pending stage contents at that edge, per REQ-017.
REQ-019 A flush with stall SHALL discard the pending contents, with no commit.
REQ-020 Latency: data sampled at edge N SHALL be visible via bypass after edge N, and SHALL be in the array after the next non-stalled edge.
REQ-021 Register 0 SHALL always read 0: writes with wa=0 never set valid, and rd1/rd2/dbg_d return 0 for address 0.
REQ-022 rd1 and rd2 SHALL be combinational.
REQ-023 rd1/rd2 bypass: if stage valid=1 and addr equals the read address (nonzero), SHALL return the stage data; otherwise SHALL return the array entry.
REQ-024 Bypass SHALL apply during stall.
REQ-025 dbg_d SHALL return array[dbg_a] only; it SHALL NOT show uncommitted stage data.
REQ-026 wb_valid and wb_addr SHALL reflect the stage register directly.
REQ-027 commit_cnt SHALL wrap from 16'hFFFF to 0.

Reset
REQ-028 rst_n=0 SHALL immediately clear all 32 array entries to 0, clear stage valid/addr/data to 0, and clear commit_cnt to 0, without waiting for clk.
REQ-029 During reset, rd1, rd2, dbg_d, wb_valid, wb_addr and commit_cnt SHALL read 0.
REQ-030 Reset asserted mid-operation SHALL discard any pending stage write.
REQ-031 Release of rst_n SHALL take effect at the first following edge with normal REQ-014 loading.

Verification
REQ-032 Basic write: we=1, wa=5, wd=32'hDEADBEEF at edge N, then we=0 -> after N: rd1(ra1=5)=DEADBEEF via bypass and dbg_d(5)=0; after N+1: dbg_d(5)=DEADBEEF, commit_cnt=1.
REQ-033 Register 0: we=1, wa=0, wd=32'h1234 -> wb_valid stays 0, rd1(0)=0, commit_cnt unchanged.
REQ-034 Stall: load wa=7, wd=32'hA5 then wb_stall=1 for 3 edges -> wb_valid=1, rd2(7)=A5, dbg_d(7)=0 throughout; commit occurs at the first edge after wb_stall=0, and commit_cnt increments once.
REQ-035 Flush priority: stage holds wa=9, wd=32'h55; assert wb_stall=1 and wb_flush=1 for one edge -> wb_valid=0, array[9] stays 0, commit_cnt unchanged. Repeat with wb_stall=0 -> array[9]=55.
REQ-036 Asynchronous reset: after writes to r1..r31, pulse rst_n=0 between edges -> all reads return 0 immediately and commit_cnt=0.
REQ-037 Wrap: preload so that commit_cnt=16'hFFFF, then perform one commit -> commit_cnt=0.
